calc_seq_ctrl: RTL and testbench

//  Parametrised signed keypad-calculator sequencer: builds two signed decimal operands from digit strobes,

---
 rtl/calc_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_ctrl.sv
`default_nettype none
// calc_seq_ctrl: keypad calculator sequencer. Builds two signed decimal operands,
// runs one add/sub on an external ALU over start/finish, and flags overflow and timeout.
module calc_seq_ctrl #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid_i,
  input  logic [3:0]       key_digit_i,
  input  logic             op_valid_i,
  input  logic             op_sub_i,
  input  logic             neg_valid_i,
  input  logic             eq_valid_i,
  input  logic             clr_valid_i,
  output logic [WIDTH-1:0] alu_in1_o,
  output logic [WIDTH-1:0] alu_in2_o,
  output logic             alu_sub_o,
  output logic             alu_start_o,
  input  logic [WIDTH-1:0] alu_out_i,
  input  logic             alu_finish_i,
  output logic [WIDTH-1:0] display_o,
  output logic             result_valid_o,
  output logic             error_o,
  output logic             busy_o
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = WIDTH + 4;
  localparam logic [EW-1:0] MAX_MAG = EW'(2 ** (WIDTH - 1) - 1);

  typedef enum logic [2:0] {
    S_ENTRY1   = 3'd0,
    S_ENTRY2   = 3'd1,
    S_ALU_REQ  = 3'd2,
    S_ALU_WAIT = 3'd3,
    S_RESULT   = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mag1_q, mag1_d, mag2_q, mag2_d;
  logic             neg1_q, neg1_d, neg2_q, neg2_d;
  logic [CW-1:0]    cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic             op_q, op_d, touch2_q, touch2_d, sub_q, sub_d;
  logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d, res_q, res_d, hold_q, hold_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic [WIDTH-1:0] op1_val, op2_val, cur_mag, res_mag;
  logic [CW-1:0]    cur_cnt;
  logic [EW-1:0]    acc_ext;
  logic             res_neg, digit_ok, ovf;
  logic             do_op, do_neg, do_key;

  // Magnitudes are WIDTH wide so a chained result of -2^(WIDTH-1) keeps its magnitude.
  assign op1_val = neg1_q ? -mag1_q : mag1_q;
  assign op2_val = neg2_q ? -mag2_q : mag2_q;
  assign res_neg = res_q[WIDTH-1];
  assign res_mag = res_neg ? -res_q : res_q;
  assign cur_mag = (state_q == S_ENTRY2) ? mag2_q : mag1_q;
  assign cur_cnt = (state_q == S_ENTRY2) ? cnt2_q : cnt1_q;
  assign acc_ext = EW'(cur_mag) * EW'(10) + EW'(key_digit_i);
  assign digit_ok = (key_digit_i <= 4'd9) && (cur_cnt < CW'(MAX_DIGITS)) && (acc_ext <= MAX_MAG);

  assign ovf = sub_q ? ((in1_q[WIDTH-1] != in2_q[WIDTH-1]) && (alu_out_i[WIDTH-1] != in1_q[WIDTH-1]))
                     : ((in1_q[WIDTH-1] == in2_q[WIDTH-1]) && (alu_out_i[WIDTH-1] != in1_q[WIDTH-1]));

  // Only the highest-priority strobe of a cycle is acted on; clear is handled first.
  assign do_op  = op_valid_i & ~eq_valid_i;
  assign do_neg = neg_valid_i & ~op_valid_i & ~eq_valid_i;
  assign do_key = key_valid_i & ~neg_valid_i & ~op_valid_i & ~eq_valid_i;

  assign alu_in1_o      = in1_q;
  assign alu_in2_o      = in2_q;
  assign alu_sub_o      = sub_q;
  assign alu_start_o    = (state_q == S_ALU_REQ);
  assign busy_o         = (state_q == S_ALU_REQ) || (state_q == S_ALU_WAIT);
  assign result_valid_o = (state_q == S_RESULT);
  assign error_o        = (state_q == S_ERROR);

  always_comb begin
    display_o = '0;
    case (state_q)
      S_ENTRY1:              display_o = op1_val;
      S_ENTRY2:              display_o = touch2_q ? op2_val : op1_val;
      S_ALU_REQ, S_ALU_WAIT: display_o = hold_q;
      S_RESULT:              display_o = res_q;
      default:               display_o = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_ENTRY1;
      mag1_q   <= '0;
      mag2_q   <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      cnt1_q   <= '0;
      cnt2_q   <= '0;
      op_q     <= 1'b0;
      touch2_q <= 1'b0;
      sub_q    <= 1'b0;
      in1_q    <= '0;
      in2_q    <= '0;
      res_q    <= '0;
      hold_q   <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      mag1_q   <= mag1_d;
      mag2_q   <= mag2_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      cnt1_q   <= cnt1_d;
      cnt2_q   <= cnt2_d;
      op_q     <= op_d;
      touch2_q <= touch2_d;
      sub_q    <= sub_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      res_q    <= res_d;
      hold_q   <= hold_d;
      timer_q  <= timer_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mag1_d   = mag1_q;
    mag2_d   = mag2_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    cnt1_d   = cnt1_q;
    cnt2_d   = cnt2_q;
    op_d     = op_q;
    touch2_d = touch2_q;
    sub_d    = sub_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    res_d    = res_q;
    hold_d   = hold_q;
    timer_d  = timer_q;
    if (clr_valid_i) begin
      state_d  = S_ENTRY1;
      mag1_d   = '0;
      mag2_d   = '0;
      neg1_d   = 1'b0;
      neg2_d   = 1'b0;
      cnt1_d   = '0;
      cnt2_d   = '0;
      op_d     = 1'b0;
      touch2_d = 1'b0;
      sub_d    = 1'b0;
      in1_d    = '0;
      in2_d    = '0;
      res_d    = '0;
      hold_d   = '0;
      timer_d  = '0;
    end else begin
      case (state_q)
        S_ENTRY1: begin
          if (do_op) begin
            op_d    = op_sub_i;
            state_d = S_ENTRY2;
          end else if (do_neg) begin
            neg1_d = ~neg1_q;
          end else if (do_key && digit_ok) begin
            mag1_d = acc_ext[WIDTH-1:0];
            cnt1_d = cnt1_q + CW'(1);
          end
        end
        S_ENTRY2: begin
          if (eq_valid_i) begin
            in1_d   = op1_val;
            in2_d   = op2_val;
            sub_d   = op_q;
            hold_d  = display_o;
            state_d = S_ALU_REQ;
          end else if (do_op) begin
            op_d = op_sub_i;
          end else if (do_neg) begin
            neg2_d   = ~neg2_q;
            touch2_d = 1'b1;
          end else if (do_key && digit_ok) begin
            mag2_d   = acc_ext[WIDTH-1:0];
            cnt2_d   = cnt2_q + CW'(1);
            touch2_d = 1'b1;
          end
        end
        S_ALU_REQ: begin
          timer_d = '0;
          state_d = S_ALU_WAIT;
        end
        S_ALU_WAIT: begin
          if (alu_finish_i) begin
            res_d   = alu_out_i;
            state_d = ovf ? S_ERROR : S_RESULT;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_d = S_ERROR;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_RESULT: begin
          if (eq_valid_i) begin
            mag1_d  = res_mag;
            neg1_d  = res_neg;
            in1_d   = res_q;
            in2_d   = op2_val;
            sub_d   = op_q;
            hold_d  = res_q;
            state_d = S_ALU_REQ;
          end else if (do_op) begin
            mag1_d   = res_mag;
            neg1_d   = res_neg;
            cnt1_d   = '0;
            mag2_d   = '0;
            neg2_d   = 1'b0;
            cnt2_d   = '0;
            touch2_d = 1'b0;
            op_d     = op_sub_i;
            state_d  = S_ENTRY2;
          end else if (do_key) begin
            mag1_d   = (key_digit_i <= 4'd9) ? WIDTH'(key_digit_i) : '0;
            cnt1_d   = (key_digit_i <= 4'd9) ? CW'(1) : '0;
            neg1_d   = 1'b0;
            mag2_d   = '0;
            neg2_d   = 1'b0;
            cnt2_d   = '0;
            touch2_d = 1'b0;
            op_d     = 1'b0;
            state_d  = S_ENTRY1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_calc_seq_ctrl.sv
`default_nettype none
// tb_calc_seq_ctrl: directed and random stimulus against a calculator-level reference;
// expectations are queued and checked by an independent monitor.
module tb_calc_seq_ctrl;
  localparam int W    = 16;
  localparam int MAXD = 5;
  localparam int TO   = 12;
  localparam int MAXV = 32767;
  localparam int P_E1 = 0, P_E2 = 1, P_REQ = 2, P_WAIT = 3, P_RES = 4, P_ERR = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic key_valid, op_valid, op_sub, neg_valid, eq_valid, clr_valid, alu_finish;
  logic [3:0] key_digit;
  logic [W-1:0] alu_in1, alu_in2, alu_out, display;
  logic alu_sub, alu_start, result_valid, error, busy;

  calc_seq_ctrl #(.WIDTH(W), .MAX_DIGITS(MAXD), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .key_valid_i(key_valid), .key_digit_i(key_digit), .op_valid_i(op_valid), .op_sub_i(op_sub),
    .neg_valid_i(neg_valid), .eq_valid_i(eq_valid), .clr_valid_i(clr_valid),
    .alu_in1_o(alu_in1), .alu_in2_o(alu_in2), .alu_sub_o(alu_sub), .alu_start_o(alu_start),
    .alu_out_i(alu_out), .alu_finish_i(alu_finish),
    .display_o(display), .result_valid_o(result_valid), .error_o(error), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic busy, rv, err, start; logic [W-1:0] disp; } st_t;
  typedef struct packed { logic [W-1:0] a, b; logic sub; } req_t;
  st_t  st_q[$];
  req_t req_q[$];
  int checks = 0, errors = 0;
  bit mon_en = 0;
  bit silent = 0;

  // Calculator-level reference state.
  int ph, mag1, mag2, n1, n2, res, shown, w, rq1, rq2;
  bit neg1, neg2, op, show2, rqsub;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int val1(); return neg1 ? -mag1 : mag1; endfunction
  function automatic int val2(); return neg2 ? -mag2 : mag2; endfunction
  function automatic int disp();
    case (ph)
      P_E1: return val1();
      P_E2: return show2 ? val2() : val1();
      P_REQ, P_WAIT: return shown;
      P_RES: return res;
      default: return 0;
    endcase
  endfunction
  function automatic logic [W-1:0] alu_val();
    int t;
    t = rq1 + (rqsub ? -rq2 : rq2);
    return W'(t);
  endfunction

  task automatic m_clear();
    ph = P_E1; mag1 = 0; mag2 = 0; n1 = 0; n2 = 0; neg1 = 0; neg2 = 0;
    op = 0; show2 = 0; res = 0; shown = 0; w = 0;
  endtask

  task automatic push_status();
    st_t e;
    e.busy = (ph == P_REQ || ph == P_WAIT); e.rv = (ph == P_RES);
    e.err = (ph == P_ERR); e.start = (ph == P_REQ); e.disp = W'(disp());
    st_q.push_back(e);
  endtask

  task automatic add_digit(input int which, input int d, output bit ok);
    int m, n;
    m = (which == 1) ? mag1 : mag2;
    n = (which == 1) ? n1 : n2;
    ok = (d <= 9) && (n < MAXD) && (m * 10 + d <= MAXV);
    if (ok && which == 1) begin mag1 = m * 10 + d; n1++; end
    if (ok && which == 2) begin mag2 = m * 10 + d; n2++; end
  endtask

  task automatic launch(input int a, input int b);
    req_t r;
    shown = disp(); rq1 = a; rq2 = b; rqsub = op;
    r.a = W'(a); r.b = W'(b); r.sub = op;
    req_q.push_back(r);
    ph = P_REQ;
  endtask

  task automatic from_res();
    neg1 = (res < 0); mag1 = (res < 0) ? -res : res; n1 = 0;
  endtask

  task automatic m_step(input bit k, input int d, input bit o, input bit s, input bit n,
                        input bit e, input bit c, input bit f, input logic [W-1:0] av);
    bit ok;
    int t;
    if (c) m_clear();
    else case (ph)
      P_E1: if (!e) begin
        if (o) begin op = s; ph = P_E2; end
        else if (n) neg1 = !neg1;
        else if (k) add_digit(1, d, ok);
      end
      P_E2: begin
        if (e) launch(val1(), val2());
        else if (o) op = s;
        else if (n) begin neg2 = !neg2; show2 = 1; end
        else if (k) begin add_digit(2, d, ok); if (ok) show2 = 1; end
      end
      P_REQ: begin ph = P_WAIT; w = 0; end
      P_WAIT: begin
        if (f) begin
          t = rq1 + (rqsub ? -rq2 : rq2);
          res = int'($signed(av));
          ph = (t > MAXV || t < -MAXV - 1) ? P_ERR : P_RES;
        end else begin
          w++;
          if (w == TO) ph = P_ERR;
        end
      end
      P_RES: begin
        if (e) begin from_res(); launch(res, val2()); end
        else if (o) begin from_res(); mag2 = 0; neg2 = 0; n2 = 0; show2 = 0; op = s; ph = P_E2; end
        else if (!n && k) begin m_clear(); if (d <= 9) begin mag1 = d; n1 = 1; end end
      end
      default: ;
    endcase
    push_status();
  endtask

  task automatic cyc(input bit k = 0, input int d = 0, input bit o = 0, input bit s = 0,
                     input bit n = 0, input bit e = 0, input bit c = 0, input bit f = 0,
                     input logic [W-1:0] av = '0);
    key_valid = k; key_digit = 4'(d); op_valid = o; op_sub = s; neg_valid = n;
    eq_valid = e; clr_valid = c; alu_finish = f; alu_out = av;
    m_step(k, d, o, s, n, e, c, f, av);
    @(posedge clk); #1;
  endtask

  task automatic key(input int d); cyc(.k(1), .d(d)); endtask
  task automatic reply(input int delay);
    for (int i = 0; i < delay; i++) cyc();
    cyc(.f(1), .av(alu_val()));
  endtask

  task automatic apply_reset();
    mon_en = 0; st_q.delete(); req_q.delete();
    key_valid = 0; key_digit = 0; op_valid = 0; op_sub = 0; neg_valid = 0;
    eq_valid = 0; clr_valid = 0; alu_finish = 0; alu_out = '0;
    reset = 1; m_clear();
    #1;
    chk("rst_busy", busy, 0); chk("rst_start", alu_start, 0); chk("rst_error", error, 0);
    chk("rst_result_valid", result_valid, 0); chk("rst_display", display, 0);
    @(negedge clk);
    chk("rst_alu_in1", alu_in1, 0); chk("rst_alu_in2", alu_in2, 0); chk("rst_alu_sub", alu_sub, 0);
    @(posedge clk); #1;
    reset = 0;
    push_status();
    mon_en = 1;
  endtask

  always @(negedge clk) begin : monitor
    st_t ex;
    req_t rx;
    if (mon_en) begin
      if (st_q.size() == 0) chk("status_queue_underrun", 1, 0);
      else begin
        ex = st_q.pop_front();
        chk("busy", busy, ex.busy); chk("result_valid", result_valid, ex.rv);
        chk("error", error, ex.err); chk("alu_start", alu_start, ex.start);
        chk("display", display, ex.disp);
      end
      if (alu_start) begin
        if (req_q.size() == 0) chk("unexpected_alu_start", 1, 0);
        else begin
          rx = req_q.pop_front();
          chk("alu_in1", alu_in1, rx.a); chk("alu_in2", alu_in2, rx.b); chk("alu_sub", alu_sub, rx.sub);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    #1;
    apply_reset();
    // 123 + 45
    key(1); key(2); key(3); cyc(.o(1), .s(0)); key(4); key(5); cyc(.e(1)); cyc(); reply(3); cyc(); cyc(.c(1));
    // 5 - 12
    key(5); cyc(.o(1), .s(1)); key(1); key(2); cyc(.e(1)); cyc(); reply(1); cyc(); cyc(.c(1));
    // 32767 + 1 overflows
    key(3); key(2); key(7); key(6); key(7); cyc(.o(1)); key(1); cyc(.e(1)); cyc(); reply(0);
    cyc(); cyc(); cyc(.c(1)); cyc();
    // magnitude limit, digit-count limit, sign toggle
    key(3); key(2); key(7); key(6); key(9); cyc(.n(1)); cyc(.c(1));
    key(1); key(2); key(3); key(4); key(5); key(6); key(11); cyc(.n(1)); cyc(.c(1));
    // chaining with op, then repeated equals; strobe priority in ENTRY2
    key(2); cyc(.o(1)); key(3); cyc(.e(1)); cyc(); reply(2);
    cyc(.o(1)); key(4); cyc(.e(1)); cyc(); reply(1);
    cyc(.e(1)); cyc(); reply(0);
    cyc(.o(1), .s(1)); cyc(.k(1), .d(7), .o(1), .s(0), .n(1)); cyc(.k(1), .d(2), .n(1), .e(1)); cyc(); reply(0);
    cyc(.c(1));
    // silent ALU -> timeout
    key(7); cyc(.o(1)); key(8); cyc(.e(1));
    chk("t6_alu_start", alu_start, 1);
    n = 0;
    while (!error && n < 3 * TO) begin cyc(); n++; end
    chk("t6_timeout_latency", n, TO + 1);
    cyc(.c(1));
    // clear and reset while waiting on the ALU
    key(1); cyc(.o(1)); key(1); cyc(.e(1)); cyc(); cyc(); cyc(.c(1)); cyc();
    chk("t6_clr_no_start", alu_start, 0);
    key(1); cyc(.o(1)); key(1); cyc(.e(1)); cyc(); cyc(.f(1), .av(16'h1234));
    apply_reset();
    // random
    for (int i = 0; i < 4000; i++) begin
      bit k, o, s, ng, e, c, f;
      int d;
      logic [W-1:0] av;
      if (ph == P_REQ) silent = ($urandom % 6 == 0);
      k = ($urandom % 2 == 0); d = $urandom % 12; o = ($urandom % 10 == 0); s = $urandom % 2;
      ng = ($urandom % 12 == 0); e = ($urandom % 8 == 0); c = ($urandom % 70 == 0);
      f = ($urandom % 15 == 0); av = W'($urandom);
      if (ph == P_WAIT) begin f = !silent && ($urandom % 3 == 0); av = alu_val(); end
      if (ph == P_ERR && $urandom % 4 == 0) c = 1;
      cyc(k, d, o, s, ng, e, c, f, av);
      if (i % 1500 == 1499) apply_reset();
    end
    cyc(); cyc();
    @(negedge clk); #1;
    mon_en = 0;
    chk("status_queue_drained", st_q.size(), 0);
    chk("request_queue_drained", req_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
